// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - MIPS32 5-stage pipeline sequencer: enables, bubbles, hazards, halt drain, counters
module pipe_ctrl_unit #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             mem_busy,
    input  logic             branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_t     state, state_nxt;
    logic [3:0] drain_cnt, drain_nxt;
    logic       hazard;
    logic       flush_inc;

    // $0 is hardwired zero, so a load targeting it never creates a dependency
    assign hazard = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        state_nxt  = state;
        drain_nxt  = drain_cnt;
        flush_inc  = 1'b0;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        running    = 1'b0;
        halted     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (start) state_nxt = RUN;
                end
                RUN: begin
                    running = 1'b1;
                    if (mem_busy) begin
                        // full freeze: defaults already hold everything
                    end else if (branch_taken) begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                        {ifid_flush, idex_flush} = 2'b11;
                        flush_inc = 1'b1;
                    end else if (hazard) begin
                        {idex_en, exmem_en, memwb_en} = 3'b111;
                        idex_flush = 1'b1;
                    end else if (halt_req) begin
                        {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
                        ifid_flush = 1'b1;
                        state_nxt  = DRAIN;
                        drain_nxt  = DRAIN_INIT;
                    end else begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                    end
                end
                DRAIN: begin
                    running = 1'b1;
                    if (mem_busy) begin
                        // frozen; the drain count only advances on cycles that move
                    end else if (branch_taken) begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                        {ifid_flush, idex_flush} = 2'b11;
                        flush_inc = 1'b1;
                        state_nxt = RUN;
                        drain_nxt = 4'd0;
                    end else begin
                        {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
                        ifid_flush = 1'b1;
                        if (drain_cnt <= 4'd1) begin
                            state_nxt = HALTED;
                            drain_nxt = 4'd0;
                        end else begin
                            drain_nxt = drain_cnt - 4'd1;
                        end
                    end
                end
                HALTED: begin
                    halted = 1'b1;
                    if (start) state_nxt = RUN;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= 4'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            if (running && !pc_en) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc)         flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - scoreboard bench for pipe_ctrl_unit
module tb_pipe_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst, start, halt_req, id_uses_rt, ex_memread, mem_busy, branch_taken;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, running, halted;
    logic [31:0] stall_cnt, flush_cnt;

    pipe_ctrl_unit #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_busy(mem_busy),
        .branch_taken(branch_taken), .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .running(running),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3;

    int          n_cmp = 0, n_err = 0;
    int          m_st, m_nst, m_dc, m_ndc;
    logic [31:0] m_stall, m_flush;
    logic        m_sinc, m_finc;
    logic [8:0]  exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // expected {pc_en,ifid_en,idex_en,exmem_en,memwb_en,ifid_flush,idex_flush,running,halted}
    function automatic logic [8:0] model_eval();
        logic [8:0] o;
        logic       hz;
        hz = ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        o = 9'b0; m_nst = m_st; m_ndc = m_dc; m_sinc = 0; m_finc = 0;
        if (rst) begin
            m_st = M_IDLE; m_dc = 0; m_stall = 0; m_flush = 0; m_nst = M_IDLE;
            return o;
        end
        case (m_st)
            M_IDLE:   if (start) m_nst = M_RUN;
            M_HALTED: begin o = 9'b000000001; if (start) m_nst = M_RUN; end
            M_RUN: begin
                if (mem_busy)          o = 9'b000000010;
                else if (branch_taken) begin o = 9'b111111110; m_finc = 1; end
                else if (hz)           o = 9'b001110110;
                else if (halt_req)     begin o = 9'b011111010; m_nst = M_DRAIN; m_ndc = 4; end
                else                   o = 9'b111110010;
            end
            default: begin
                if (mem_busy)          o = 9'b000000010;
                else if (branch_taken) begin o = 9'b111111110; m_finc = 1; m_nst = M_RUN; m_ndc = 0; end
                else begin
                    o = 9'b011111010;
                    if (m_dc == 1) m_nst = M_HALTED; else m_ndc = m_dc - 1;
                end
            end
        endcase
        m_sinc = o[1] && !o[8];
        return o;
    endfunction

    task automatic tick();
        logic [8:0] g, e;
        exp_q.push_back(model_eval());
        #2;
        g = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, running, halted};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("outs", 32'(g), 32'(e));
        end
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        @(posedge clk);
        if (!rst) begin
            m_st = m_nst; m_dc = m_ndc;
            if (m_sinc) m_stall++;
            if (m_finc) m_flush++;
        end
        @(negedge clk);
    endtask

    task automatic clr();
        start = 0; halt_req = 0; id_uses_rt = 0; ex_memread = 0; mem_busy = 0; branch_taken = 0;
        id_rs = 0; id_rt = 0; ex_rt = 0;
    endtask

    logic [31:0] s0;

    initial begin
        clr(); rst = 1;
        m_st = M_IDLE; m_dc = 0; m_stall = 0; m_flush = 0;
        @(negedge clk);
        tick(); tick();
        rst = 0; tick();
        start = 1; tick();
        start = 0; tick(); tick();
        chk("run_after_start", 32'(running), 32'd1);

        // load-use on rs, then $0 (no stall), then rt hazard, then rt unused
        ex_memread = 1; ex_rt = 8; id_rs = 8; tick();
        chk("stall_rs", stall_cnt, 32'd1);
        ex_rt = 0; id_rs = 0; tick();
        ex_rt = 9; id_rs = 3; id_rt = 9; id_uses_rt = 1; tick();
        id_uses_rt = 0; tick();
        chk("stall_rt", stall_cnt, 32'd2);

        // squash beats hazard and halt
        ex_rt = 8; id_rs = 8; halt_req = 1; branch_taken = 1; tick();
        clr(); tick();
        chk("flush_one", flush_cnt, 32'd1);
        chk("still_run", 32'(running & ~halted), 32'd1);

        s0 = stall_cnt;
        mem_busy = 1; tick(); tick(); tick();
        mem_busy = 0; tick();
        chk("busy_stalls", stall_cnt - s0, 32'd3);

        // halt with a busy cycle on the second drain cycle
        halt_req = 1; tick();
        halt_req = 0; tick();
        mem_busy = 1; tick();
        mem_busy = 0; tick(); tick();
        #1 chk("not_yet_halted", 32'(halted), 32'd0);
        tick();
        #1 chk("halt_latency", 32'(halted), 32'd1);
        tick();
        start = 1; tick();
        start = 0; tick();
        chk("resume", 32'(running), 32'd1);

        // branch in first drain cycle cancels the halt
        halt_req = 1; tick();
        halt_req = 0; branch_taken = 1; tick();
        branch_taken = 0; for (int i = 0; i < 6; i++) tick();
        chk("no_halt", 32'(halted), 32'd0);

        for (int i = 0; i < 300; i++) begin
            start        = ($urandom_range(0, 9) == 0);
            halt_req     = ($urandom_range(0, 7) == 0);
            mem_busy     = ($urandom_range(0, 5) == 0);
            branch_taken = ($urandom_range(0, 9) == 0);
            ex_memread   = $urandom_range(0, 1);
            id_uses_rt   = $urandom_range(0, 1);
            ex_rt        = 5'($urandom_range(0, 3));
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            tick();
        end

        // reset mid-drain aborts immediately
        clr(); rst = 1; tick(); rst = 0;
        start = 1; tick(); start = 0;
        halt_req = 1; tick(); halt_req = 0; tick();
        rst = 1; tick();
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_flush", flush_cnt, 32'd0);
        rst = 0; tick();
        chk("rst_idle", 32'(running | halted), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Central sequencer for the 5-stage MIPS32 pipeline.
- Generates the PC enable, the per-stage load enables and the flush (bubble) controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use hazards, data-memory wait states, taken-branch squashes and HALT drain.
- Keeps stall and flush performance counters.

Parameters:
- DRAIN_CYCLES, 4, non-busy cycles spent draining after HALT before entering HALTED (1..15).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  pulse: begin or resume execution
- halt_req  input  1  HALT instruction decoded in ID
- id_rs  input  5  rs field of the instruction in ID
- id_rt  input  5  rt field of the instruction in ID
- id_uses_rt  input  1  ID instruction reads rt
- ex_memread  input  1  instruction in EX is a load
- ex_rt  input  5  destination of the load in EX
- mem_busy  input  1  data memory not ready this cycle
- branch_taken  input  1  branch/jump resolved taken in EX
- pc_en  output  1  PC register load enable
- ifid_en, idex_en, exmem_en, memwb_en  output  1 each  pipeline register load enables
- ifid_flush, idex_flush  output  1 each  load a bubble (NOP) instead of the data input
- running  output  1  state is RUN or DRAIN
- halted  output  1  state is HALTED
- stall_cnt  output  CNT_W  cycles with pc_en=0 while running
- flush_cnt  output  CNT_W  taken-branch squashes

Behaviour:
- States: IDLE, RUN, DRAIN, HALTED. State, drain counter and performance counters are registered.
- Enable and flush outputs are combinational from state and the current inputs.
- Reset:
  - rst=1 forces state to IDLE, clears the drain counter, stall_cnt and flush_cnt.
  - While rst is asserted, all enables and flushes are 0, and running=0, halted=0.
  - A reset asserted mid-operation aborts immediately, with no drain.
- IDLE:
  - All enables and flushes are 0.
  - start=1 moves to RUN on the next edge.
- RUN uses a fixed priority; the highest active condition decides the outputs for the cycle:
  1. mem_busy=1: every enable is 0 and every flush is 0 (full freeze).
  2. branch_taken=1:
     - All enables are 1, ifid_flush=1 and idex_flush=1.
     - This squashes the two younger instructions; flush_cnt increments.
     - Any halt_req or hazard in the same cycle is ignored because the ID instruction is squashed.
  3. Load-use hazard, defined as ex_memread and ex_rt!=0 and (ex_rt==id_rs, or id_uses_rt and ex_rt==id_rt):
     - pc_en=0, ifid_en=0.
     - idex_en=1 with idex_flush=1, exmem_en=1, memwb_en=1.
     - A halt_req in the same cycle is deferred, because ID is stalled and the condition is re-evaluated next cycle.
  4. halt_req=1:
     - pc_en=0; ifid_en=1 with ifid_flush=1; the other enables are 1.
     - The next state is DRAIN, with the drain counter loaded to DRAIN_CYCLES.
  5. Otherwise, all enables are 1 and all flushes are 0.
- DRAIN:
  - pc_en=0; ifid_en=1 with ifid_flush=1; the remaining enables are 1.
  - mem_busy=1 freezes all enables; the counter does not decrement.
  - Each non-busy cycle decrements the counter. When it reaches 1 and the cycle is non-busy, go to HALTED.
  - branch_taken=1 during DRAIN means an older branch squashed the HALT:
    - Apply the priority-2 outputs.
    - Clear the counter and return to RUN.
  - start is ignored.
- HALTED:
  - All enables are 0 and halted=1.
  - start=1 moves to RUN; the PC resumes from its held value.
- Register $0 never produces a hazard.
- The ID/EX flush overrides data; every stage with en=1 and flush=1 captures a NOP.
- stall_cnt increments in every RUN or DRAIN cycle with pc_en=0 caused by mem_busy, load-use or drain.
- Both counters wrap modulo 2^CNT_W with no saturation.

Test Plan:
- Reset, then start at cycle 2 → IDLE outputs all 0 until cycle 3; from cycle 3 all enables are 1, running=1.
- RUN with ex_memread=1, ex_rt=8, id_rs=8 for 1 cycle → pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; stall_cnt goes 0→1. Repeat with ex_rt=0 → no stall.
- branch_taken=1 together with a load-use hazard and halt_req → all enables 1, ifid_flush=idex_flush=1, flush_cnt=1, state stays RUN.
- mem_busy held 3 cycles during RUN → all enables and flushes 0 for exactly 3 cycles, stall_cnt=3, then normal operation resumes.
- halt_req with DRAIN_CYCLES=4 and mem_busy=1 on the second drain cycle → halted asserts after 5 cycles. Then start → RUN.
- halt_req, then branch_taken on the first DRAIN cycle → squash outputs, return to RUN, halted never asserts. Also: rst asserted mid-DRAIN → IDLE immediately, counters 0.
